// File: rtl/ln_var_bf16_gen.sv
// LayerNorm variance stage: accumulates N signed elements, emits bf16((N*sumsq - sum^2 + eps)/N^2) and the vector sum.
// Latency: x_vld two edges after the N-th accept; in_rdy drops for 2 cycles per vector, x has no backpressure.
module ln_var_bf16_gen #(
    parameter int DATA_W     = 8,
    parameter int LOG2_N     = 6,
    parameter int EPS_SCALED = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic signed [DATA_W-1:0]         in_data,
    input  logic                             in_vld,
    output logic                             in_rdy,
    output logic [15:0]                      x,
    output logic                             x_vld,
    output logic signed [DATA_W+LOG2_N-1:0]  sum_out
);

    localparam int SW = DATA_W + LOG2_N;
    localparam int QW = 2*DATA_W + LOG2_N;
    localparam int VW = 2*DATA_W + 2*LOG2_N + 1;
    localparam int PW = $clog2(VW);
    localparam int NW = VW + 9;

    typedef enum logic [1:0] {ACC, CALC, NORM} state_t;

    state_t                  state, state_nxt;
    logic [LOG2_N-1:0]       cnt;
    logic signed [SW-1:0]    sum;
    logic [QW-1:0]           sumsq;
    logic [VW-1:0]           v;
    logic                    accept;

    logic signed [2*DATA_W-1:0] din_ext, din_sq;
    logic [VW-1:0]              nsumsq_w, v_nxt;
    logic signed [VW-1:0]       sum_w, sum_sq_w;

    logic [PW-1:0]  p, shamt;
    logic [NW-2:0]  norm;
    logic [6:0]     frac;
    logic           guard, sticky, round_up;
    logic [7:0]     frac_r, exp_w;
    logic [15:0]    x_nxt;

    always_comb begin
        state_nxt = state;
        in_rdy    = 1'b0;
        case (state)
            ACC: begin
                in_rdy = 1'b1;
                if (in_vld && (cnt == {LOG2_N{1'b1}}))
                    state_nxt = CALC;
            end
            CALC:    state_nxt = NORM;
            NORM:    state_nxt = ACC;
            default: state_nxt = ACC;
        endcase
    end

    assign accept = in_vld & in_rdy;

    // Squares are non-negative, so the signed product is reused as an unsigned magnitude.
    assign din_ext = (2*DATA_W)'(in_data);
    assign din_sq  = din_ext * din_ext;

    // N*sumsq >= sum^2 always, so modular VW-bit arithmetic gives the exact result.
    assign nsumsq_w = VW'(sumsq) << LOG2_N;
    assign sum_w    = VW'(sum);
    assign sum_sq_w = sum_w * sum_w;
    assign v_nxt    = nsumsq_w - $unsigned(sum_sq_w) + VW'(EPS_SCALED);

    always_comb begin
        p = '0;
        for (int i = 0; i < VW; i++)
            if (v[i]) p = PW'(i);
    end

    // Left-justify v so the leading one falls off the top; padding zeros cover narrow v.
    assign shamt    = PW'(VW-1) - p;
    assign norm     = (NW-1)'({v, 9'b0} << shamt);
    assign frac     = norm[NW-2 -: 7];
    assign guard    = norm[NW-9];
    assign sticky   = |norm[NW-10:0];
    assign round_up = guard & (sticky | frac[0]);
    assign frac_r   = {1'b0, frac} + 8'(round_up);
    assign exp_w    = 8'd127 + 8'(p) - 8'(2*LOG2_N) + 8'(frac_r[7]);
    assign x_nxt    = (v == '0) ? 16'h0000 : {1'b0, exp_w, frac_r[6:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ACC;
            cnt     <= '0;
            sum     <= '0;
            sumsq   <= '0;
            v       <= '0;
            x       <= 16'h0000;
            x_vld   <= 1'b0;
            sum_out <= '0;
        end else begin
            state <= state_nxt;
            x_vld <= 1'b0;
            case (state)
                ACC: begin
                    if (accept) begin
                        cnt   <= cnt + LOG2_N'(1);
                        sum   <= sum + SW'(in_data);
                        sumsq <= sumsq + QW'($unsigned(din_sq));
                    end
                end
                CALC: v <= v_nxt;
                NORM: begin
                    x       <= x_nxt;
                    x_vld   <= 1'b1;
                    sum_out <= sum;
                    sum     <= '0;
                    sumsq   <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule
